// File: rtl/conv_sequencer.sv
// Control FSM rastering a convolution window over an image: fetch window,
// fire the MAC, capture its result and write it to the output buffer.
module conv_sequencer #(
  parameter int IMAGE_WIDTH  = 5,
  parameter int IMAGE_HEIGHT = 5,
  parameter int FILTER_SIZE  = 3,
  parameter int OUT_W        = IMAGE_WIDTH - FILTER_SIZE + 1,
  parameter int OUT_H        = IMAGE_HEIGHT - FILTER_SIZE + 1,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        win_row,
  output logic [7:0]        win_col,
  output logic              win_req,
  input  logic              win_ack,
  output logic              mult_en,
  input  logic [15:0]       result_in,
  input  logic              result_valid_in,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_data
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic             last_col;
  logic             last_pos;
  logic             timeout_hit;

  assign last_col    = (win_col == 8'(OUT_W - 1));
  assign last_pos    = last_col && (win_row == 8'(OUT_H - 1));
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = FETCH;
      FETCH: if (win_ack) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (result_valid_in)  state_nx = WRITE;
        else if (timeout_hit) state_nx = DONE;
      end
      WRITE:   state_nx = last_pos ? DONE : FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Strobes are decoded from the next state so every output is a flop
  // that is already valid in the first cycle of the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      win_req  <= 1'b0;
      mult_en  <= 1'b0;
      out_we   <= 1'b0;
      win_row  <= '0;
      win_col  <= '0;
      out_addr <= '0;
      out_data <= '0;
      wait_cnt <= '0;
    end else begin
      busy     <= (state_nx != IDLE);
      win_req  <= (state_nx == FETCH);
      mult_en  <= (state_nx == ISSUE);
      out_we   <= (state_nx == WRITE);
      done     <= (state_nx == DONE);
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;

      if (state == IDLE && state_nx == FETCH) begin
        win_row <= '0;
        win_col <= '0;
        error   <= 1'b0;
      end

      if (state == WAIT && state_nx == DONE) error <= 1'b1;

      if (state == WAIT && state_nx == WRITE) begin
        out_data <= result_in;
        out_addr <= ADDR_W'(32'(win_row) * OUT_W + 32'(win_col));
      end

      if (state == WRITE && !abort) begin
        if (last_col) begin
          win_col <= '0;
          win_row <= last_pos ? '0 : win_row + 8'd1;
        end else begin
          win_col <= win_col + 8'd1;
        end
      end
    end
  end

endmodule
